dtree_seq_eval: RTL and testbench



---
 rtl/dtree_seq_eval.sv | 172 +++++++++++++++++
 tb/tb_dtree_seq_eval.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree evaluator: walks a configurable node table one node per
// cycle from node 0 until a leaf is reached or the walk faults.
module dtree_seq_eval #(
  parameter int N_FEAT    = 45,
  parameter int FEAT_W    = 8,
  parameter int CLASS_W   = 5,
  parameter int N_NODES   = 64,
  parameter int MAX_DEPTH = 16,
  localparam int NODE_AW  = $clog2(N_NODES),
  localparam int FIDX_W   = $clog2(N_FEAT),
  localparam int PREC_W   = $clog2(FEAT_W + 1),
  localparam int NODE_W   = 1 + FIDX_W + PREC_W + FEAT_W + 2 * NODE_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [NODE_AW-1:0]       cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data,
  output logic                     cfg_ready
);

  localparam int STEP_W   = $clog2(MAX_DEPTH + 1);
  localparam int LEFT_LSB = NODE_AW;
  localparam int THR_LSB  = 2 * NODE_AW;
  localparam int PREC_LSB = THR_LSB + FEAT_W;
  localparam int FIDX_LSB = PREC_LSB + PREC_W;
  localparam int LEAF_BIT = NODE_W - 1;
  localparam logic [NODE_W-1:0] RESET_NODE = {1'b1, {(NODE_W-1){1'b0}}};

  if (CLASS_W > NODE_AW) begin : g_class_w_check
    $error("CLASS_W must not exceed NODE_AW");
  end

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t              state;
  logic                idle_q;
  logic                valid_q;
  logic [NODE_W-1:0]   nodes [N_NODES];
  logic [FEAT_W-1:0]   feat  [N_FEAT];
  logic [NODE_AW-1:0]  ptr;
  logic [STEP_W-1:0]   step;

  logic [NODE_W-1:0]   cur;
  logic                cur_leaf;
  logic [FIDX_W-1:0]   cur_fidx;
  logic [PREC_W-1:0]   cur_prec;
  logic [FEAT_W-1:0]   cur_thr;
  logic [NODE_AW-1:0]  cur_left;
  logic [NODE_AW-1:0]  cur_right;
  logic [PREC_W-1:0]   prec_eff;
  logic [FEAT_W-1:0]   sel_feat;
  logic [FEAT_W-1:0]   feat_top;
  logic [FEAT_W-1:0]   thr_low;
  logic                go_left;
  logic [NODE_AW-1:0]  nxt;
  logic                fidx_bad;
  logic                ptr_bad;
  logic                depth_hit;
  logic                fault;

  assign cur       = nodes[ptr];
  assign cur_leaf  = cur[LEAF_BIT];
  assign cur_fidx  = cur[FIDX_LSB +: FIDX_W];
  assign cur_prec  = cur[PREC_LSB +: PREC_W];
  assign cur_thr   = cur[THR_LSB +: FEAT_W];
  assign cur_left  = cur[LEFT_LSB +: NODE_AW];
  assign cur_right = cur[0 +: NODE_AW];

  // Compare only the top prec_eff bits of the feature against the low prec_eff
  // bits of the threshold; prec 0 or out of range means a full-width compare.
  always_comb begin
    sel_feat = '0;
    for (int unsigned i = 0; i < N_FEAT; i++) begin
      if (cur_fidx == FIDX_W'(i)) sel_feat = feat[i];
    end
    prec_eff = (cur_prec == '0 || cur_prec > PREC_W'(FEAT_W)) ? PREC_W'(FEAT_W) : cur_prec;
    feat_top = sel_feat >> (PREC_W'(FEAT_W) - prec_eff);
    thr_low  = cur_thr & ~({FEAT_W{1'b1}} << prec_eff);
    go_left  = feat_top <= thr_low;
    nxt      = go_left ? cur_left : cur_right;
  end

  if (N_FEAT < 2 ** FIDX_W) begin : g_fidx_chk
    assign fidx_bad = cur_fidx >= FIDX_W'(N_FEAT);
  end else begin : g_fidx_full
    assign fidx_bad = 1'b0;
  end

  if (N_NODES < 2 ** NODE_AW) begin : g_ptr_chk
    assign ptr_bad = nxt >= NODE_AW'(N_NODES);
  end else begin : g_ptr_full
    assign ptr_bad = 1'b0;
  end

  assign depth_hit = step == STEP_W'(MAX_DEPTH - 1);
  assign fault     = fidx_bad | ptr_bad | depth_hit;

  assign in_ready  = idle_q;
  assign cfg_ready = idle_q;
  assign out_valid = valid_q;

  // Table writes land on the accept edge, so the first node read already sees them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_NODES; i++) nodes[i] <= RESET_NODE;
    end else if (cfg_we && state == IDLE) begin
      nodes[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idle_q    <= 1'b1;
      valid_q   <= 1'b0;
      out_class <= '0;
      out_err   <= 1'b0;
      ptr       <= '0;
      step      <= '0;
      for (int unsigned i = 0; i < N_FEAT; i++) feat[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int unsigned i = 0; i < N_FEAT; i++) feat[i] <= in_feat[i*FEAT_W +: FEAT_W];
            ptr    <= '0;
            step   <= '0;
            state  <= WALK;
            idle_q <= 1'b0;
          end
        end
        WALK: begin
          if (cur_leaf) begin
            out_class <= cur_left[CLASS_W-1:0];
            out_err   <= 1'b0;
            state     <= DONE;
            valid_q   <= 1'b1;
          end else if (fault) begin
            out_class <= '1;
            out_err   <= 1'b1;
            state     <= DONE;
            valid_q   <= 1'b1;
          end else begin
            ptr  <= nxt;
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Directed bench for dtree_seq_eval: hand-built node tables with hand-computed
// class, error flag and latency for each walk.
module tb_dtree_seq_eval;
  localparam int N_FEAT    = 45;
  localparam int FEAT_W    = 8;
  localparam int CLASS_W   = 5;
  localparam int N_NODES   = 64;
  localparam int MAX_DEPTH = 16;
  localparam int NODE_AW   = 6;
  localparam int NODE_W    = 31;
  localparam int VW        = N_FEAT * FEAT_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [VW-1:0]      in_feat = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [CLASS_W-1:0] out_class;
  logic               out_err;
  logic               cfg_we = 1'b0;
  logic [NODE_AW-1:0] cfg_addr = '0;
  logic [NODE_W-1:0]  cfg_data = '0;
  logic               cfg_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dtree_seq_eval #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
    .N_NODES(N_NODES), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_feat(in_feat), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
  );

  function automatic logic [NODE_W-1:0] mk_node(input bit leaf, input int fidx, input int prec,
                                                 input int thr, input int left, input int right);
    return {leaf, 6'(fidx), 4'(prec), 8'(thr), 6'(left), 6'(right)};
  endfunction

  function automatic logic [NODE_W-1:0] mk_leaf(input int cls);
    return mk_node(1'b1, 0, 0, 0, cls, 0);
  endfunction

  function automatic logic [VW-1:0] fv(input int idx, input logic [7:0] val);
    logic [VW-1:0] v;
    v = '0;
    v[idx*FEAT_W +: FEAT_W] = val;
    return v;
  endfunction

  task automatic cfg_write(input int a, input logic [NODE_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = 6'(a); cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic accept(input logic [VW-1:0] v);
    in_valid = 1'b1; in_feat = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input logic [VW-1:0] v, output logic [CLASS_W-1:0] c,
                         output logic e, output int lat);
    accept(v);
    wait_valid(lat);
    c = out_class;
    e = out_err;
    release_out();
  endtask

  task automatic setup_two_level();
    cfg_write(0, mk_node(1'b0, 3, 3, 3, 1, 2));
    cfg_write(1, mk_leaf(13));
    cfg_write(2, mk_leaf(2));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_class !== 5'd0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b class=%0d err=%b want 0/0/0", out_valid, out_class, out_err);
    end
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got in_ready=%b cfg_ready=%b want 1/1", in_ready, cfg_ready);
    end
  endtask

  task automatic test_default_table();
    logic [CLASS_W-1:0] c; logic e; int lat;
    run_vec(fv(7, 8'hA5), c, e, lat);
    checks++;
    if (c !== 5'd0 || e !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL default_table got class=%0d err=%b lat=%0d want 0/0/1", c, e, lat);
    end
  endtask

  task automatic test_two_level();
    logic [CLASS_W-1:0] c; logic e; int lat;
    setup_two_level();
    run_vec(fv(3, 8'h7F), c, e, lat);
    checks++;
    if (c !== 5'd13 || e !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL two_level_7f got class=%0d err=%b lat=%0d want 13/0/2", c, e, lat);
    end
    run_vec(fv(3, 8'h80), c, e, lat);
    checks++;
    if (c !== 5'd2 || e !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL two_level_80 got class=%0d err=%b lat=%0d want 2/0/2", c, e, lat);
    end
    run_vec(fv(3, 8'h60) | fv(4, 8'hFF), c, e, lat);
    checks++;
    if (c !== 5'd13 || lat !== 2) begin
      errors++;
      $display("FAIL two_level_60 got class=%0d lat=%0d want 13/2", c, lat);
    end
  endtask

  task automatic test_precision();
    logic [CLASS_W-1:0] c; logic e; int lat;
    cfg_write(0, mk_node(1'b0, 44, 0, 8'h80, 1, 2));
    run_vec(fv(44, 8'h80), c, e, lat);
    checks++;
    if (c !== 5'd13 || lat !== 2) begin
      errors++;
      $display("FAIL prec0_eq got class=%0d lat=%0d want 13/2", c, lat);
    end
    run_vec(fv(44, 8'h81), c, e, lat);
    checks++;
    if (c !== 5'd2 || lat !== 2) begin
      errors++;
      $display("FAIL prec0_gt got class=%0d lat=%0d want 2/2", c, lat);
    end
    cfg_write(0, mk_node(1'b0, 44, 9, 8'h80, 1, 2));
    run_vec(fv(44, 8'h81), c, e, lat);
    checks++;
    if (c !== 5'd2 || e !== 1'b0) begin
      errors++;
      $display("FAIL prec9_gt got class=%0d err=%b want 2/0", c, e);
    end
    cfg_write(0, mk_node(1'b0, 10, 1, 8'hFE, 1, 2));
    run_vec(fv(10, 8'h7F), c, e, lat);
    checks++;
    if (c !== 5'd13) begin
      errors++;
      $display("FAIL prec1_msb0 got class=%0d want 13", c);
    end
    run_vec(fv(10, 8'h80), c, e, lat);
    checks++;
    if (c !== 5'd2) begin
      errors++;
      $display("FAIL prec1_msb1 got class=%0d want 2", c);
    end
  endtask

  task automatic test_fidx_fault();
    logic [CLASS_W-1:0] c; logic e; int lat;
    cfg_write(0, mk_node(1'b0, 45, 0, 0, 1, 2));
    run_vec(fv(0, 8'h00), c, e, lat);
    checks++;
    if (c !== 5'd31 || e !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL fidx_fault got class=%0d err=%b lat=%0d want 31/1/1", c, e, lat);
    end
  endtask

  task automatic test_depth();
    logic [CLASS_W-1:0] c; logic e; int lat;
    cfg_write(0, mk_node(1'b0, 0, 0, 8'hFF, 0, 0));
    run_vec(fv(0, 8'h12), c, e, lat);
    checks++;
    if (c !== 5'd31 || e !== 1'b1 || lat !== 16) begin
      errors++;
      $display("FAIL depth_selfloop got class=%0d err=%b lat=%0d want 31/1/16", c, e, lat);
    end
    for (int i = 0; i < 15; i++) cfg_write(i, mk_node(1'b0, 0, 0, 8'hFF, i + 1, i + 1));
    cfg_write(15, mk_leaf(7));
    run_vec(fv(0, 8'h00), c, e, lat);
    checks++;
    if (c !== 5'd7 || e !== 1'b0 || lat !== 16) begin
      errors++;
      $display("FAIL depth_15_internal got class=%0d err=%b lat=%0d want 7/0/16", c, e, lat);
    end
    cfg_write(15, mk_node(1'b0, 0, 0, 8'hFF, 16, 16));
    cfg_write(16, mk_leaf(7));
    run_vec(fv(0, 8'h00), c, e, lat);
    checks++;
    if (c !== 5'd31 || e !== 1'b1 || lat !== 16) begin
      errors++;
      $display("FAIL depth_16_internal got class=%0d err=%b lat=%0d want 31/1/16", c, e, lat);
    end
  endtask

  task automatic test_stall_cfg_ignored();
    logic [CLASS_W-1:0] c; logic e; int lat;
    setup_two_level();
    accept(fv(3, 8'h7F));
    wait_valid(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL stall_latency got %0d want 2", lat);
    end
    in_valid = 1'b1; in_feat = fv(3, 8'h80);
    cfg_we = 1'b1; cfg_addr = 6'd1; cfg_data = mk_leaf(5);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_class !== 5'd13 || out_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b class=%0d err=%b want 1/13/0", k, out_valid, out_class, out_err);
      end
      checks++;
      if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ready cycle %0d got in_ready=%b cfg_ready=%b want 0/0", k, in_ready, cfg_ready);
      end
    end
    cfg_we = 1'b0;
    release_out();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL handoff got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    run_vec(fv(3, 8'h7F), c, e, lat);
    checks++;
    if (c !== 5'd13 || lat !== 2) begin
      errors++;
      $display("FAIL stall_readback got class=%0d lat=%0d want 13/2", c, lat);
    end
  endtask

  task automatic test_cfg_on_accept();
    int lat;
    in_valid = 1'b1; in_feat = fv(3, 8'h80);
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = mk_leaf(21);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    wait_valid(lat);
    checks++;
    if (out_class !== 5'd21 || out_err !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL cfg_on_accept got class=%0d err=%b lat=%0d want 21/0/1", out_class, out_err, lat);
    end
    release_out();
  endtask

  task automatic test_feat_hold();
    int lat;
    setup_two_level();
    accept(fv(3, 8'h7F));
    in_feat = fv(3, 8'h80);
    wait_valid(lat);
    checks++;
    if (out_class !== 5'd13 || lat !== 2) begin
      errors++;
      $display("FAIL feat_hold got class=%0d lat=%0d want 13/2", out_class, lat);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [CLASS_W-1:0] c; logic e; int lat;
    logic [7:0]         xs   [4] = '{8'h00, 8'hFF, 8'h7F, 8'h80};
    logic [CLASS_W-1:0] want [4] = '{5'd13, 5'd2, 5'd13, 5'd2};
    for (int i = 0; i < 4; i++) begin
      run_vec(fv(3, xs[i]), c, e, lat);
      checks++;
      if (c !== want[i] || e !== 1'b0 || lat !== 2) begin
        errors++;
        $display("FAIL back_to_back[%0d] got class=%0d err=%b lat=%0d want %0d/0/2", i, c, e, lat, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    logic [CLASS_W-1:0] c; logic e; int lat;
    for (int i = 0; i < 4; i++) cfg_write(i, mk_node(1'b0, 0, 0, 8'hFF, i + 1, i + 1));
    cfg_write(4, mk_leaf(9));
    run_vec(fv(0, 8'h33), c, e, lat);
    checks++;
    if (c !== 5'd9 || e !== 1'b0 || lat !== 5) begin
      errors++;
      $display("FAIL chain5 got class=%0d err=%b lat=%0d want 9/0/5", c, e, lat);
    end
    accept(fv(0, 8'h33));
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_class !== 5'd0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL midwalk_reset got valid=%b class=%0d err=%b want 0/0/0", out_valid, out_class, out_err);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midwalk_valid cycle %0d got %b want 0", k, out_valid);
      end
    end
    rst_n = 1'b1;
    run_vec(fv(0, 8'h33), c, e, lat);
    checks++;
    if (c !== 5'd0 || e !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL post_reset_table got class=%0d err=%b lat=%0d want 0/0/1", c, e, lat);
    end
  endtask

  initial begin
    test_reset();
    test_default_table();
    test_two_level();
    test_precision();
    test_fidx_fault();
    test_depth();
    test_stall_cfg_ignored();
    test_cfg_on_accept();
    test_feat_hold();
    test_back_to_back();
    test_reset_mid_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
